// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcodes, datapath width and the arbiter's FSM state encoding.
package alu_pkg;

    localparam int DATA_WIDTH = 32;

    localparam logic [2:0] ALU_ADD  = 3'b000;
    localparam logic [2:0] ALU_SUB  = 3'b001;
    localparam logic [2:0] ALU_SLT  = 3'b010;
    localparam logic [2:0] ALU_SLTU = 3'b011;
    localparam logic [2:0] ALU_XOR  = 3'b100;
    localparam logic [2:0] ALU_MUL  = 3'b101;
    localparam logic [2:0] ALU_OR   = 3'b110;
    localparam logic [2:0] ALU_AND  = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_e;

    function automatic logic [2:0] pack_flags(input logic ovf, input logic cout, input logic zero);
        return {ovf, cout, zero};
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first requester after 'last', wrapping at NREQ.
// Returns a one-hot grant, its index and whether anything was requesting.
module rr_picker #(
    parameter int NREQ = 2,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  last_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IDW-1:0]  idx_o,
    output logic            any_o
);

    localparam logic [NREQ-1:0] ONE = {{(NREQ-1){1'b0}}, 1'b1};

    always_comb begin
        int              cand;
        logic [NREQ-1:0] req_sh;
        gnt_o  = '0;
        idx_o  = '0;
        any_o  = 1'b0;
        cand   = 0;
        req_sh = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand   = (int'(last_i) + k) % NREQ;
            req_sh = req_i >> cand;
            if (!any_o && req_sh[0]) begin
                any_o = 1'b1;
                gnt_o = ONE << cand;
                idx_o = IDW'(cand);
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational ALU among NREQ requesters, one operation
// in flight; operands and results are registered around the ALU (accept T -> rsp_valid T+2).
module alu_arbiter #(
    parameter int DATA_WIDTH = alu_pkg::DATA_WIDTH,
    parameter int NREQ       = 2,
    parameter int IDW        = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NREQ-1:0]            req_valid,
    output logic [NREQ-1:0]            req_ready,
    input  logic [NREQ*DATA_WIDTH-1:0] req_A,
    input  logic [NREQ*DATA_WIDTH-1:0] req_B,
    input  logic [NREQ*3-1:0]          req_ALUop,
    output logic [NREQ-1:0]            rsp_valid,
    input  logic [NREQ-1:0]            rsp_ready,
    output logic [DATA_WIDTH-1:0]      rsp_Result,
    output logic [2:0]                 rsp_flags,
    output logic [DATA_WIDTH-1:0]      alu_A,
    output logic [DATA_WIDTH-1:0]      alu_B,
    output logic [2:0]                 alu_ALUop,
    input  logic [DATA_WIDTH-1:0]      alu_Result,
    input  logic                       alu_Overflow,
    input  logic                       alu_CarryOut,
    input  logic                       alu_Zero,
    output logic                       busy
);

    import alu_pkg::*;

    arb_state_e            state_q;
    logic [NREQ-1:0]       gnt_oh_q;
    logic [IDW-1:0]        gnt_q;
    logic [IDW-1:0]        last_q;
    logic [DATA_WIDTH-1:0] a_q;
    logic [DATA_WIDTH-1:0] b_q;
    logic [2:0]            op_q;
    logic [DATA_WIDTH-1:0] res_q;
    logic [2:0]            flags_q;
    logic [NREQ-1:0]       rsp_valid_q;
    logic                  busy_q;

    logic [NREQ-1:0]       pick_gnt;
    logic [IDW-1:0]        pick_idx;
    logic                  pick_any;
    logic [DATA_WIDTH-1:0] sel_a;
    logic [DATA_WIDTH-1:0] sel_b;
    logic [2:0]            sel_op;
    logic                  rsp_done;

    rr_picker #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_picker (
        .req_i  (req_valid),
        .last_i (last_q),
        .gnt_o  (pick_gnt),
        .idx_o  (pick_idx),
        .any_o  (pick_any)
    );

    always_comb begin
        sel_a  = '0;
        sel_b  = '0;
        sel_op = ALU_ADD;
        for (int i = 0; i < NREQ; i++) begin
            if (pick_gnt[i]) begin
                sel_a  = req_A[i*DATA_WIDTH +: DATA_WIDTH];
                sel_b  = req_B[i*DATA_WIDTH +: DATA_WIDTH];
                sel_op = req_ALUop[i*3 +: 3];
            end
        end
    end

    // Gated by rst so the ready drops the moment reset is asserted, not at the next edge.
    assign req_ready = (state_q == IDLE && pick_any && !rst) ? pick_gnt : '0;
    // Only the granted requester's ready bit completes the response.
    assign rsp_done  = (state_q == RESP) && (|(rsp_valid_q & rsp_ready));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            gnt_oh_q    <= '0;
            gnt_q       <= '0;
            last_q      <= IDW'(NREQ - 1);
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= ALU_ADD;
            res_q       <= '0;
            flags_q     <= '0;
            rsp_valid_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_any) begin
                        a_q      <= sel_a;
                        b_q      <= sel_b;
                        op_q     <= sel_op;
                        gnt_q    <= pick_idx;
                        gnt_oh_q <= pick_gnt;
                        busy_q   <= 1'b1;
                        state_q  <= EXEC;
                    end
                end
                EXEC: begin
                    res_q       <= alu_Result;
                    flags_q     <= pack_flags(alu_Overflow, alu_CarryOut, alu_Zero);
                    rsp_valid_q <= gnt_oh_q;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (rsp_done) begin
                        last_q      <= gnt_q;
                        rsp_valid_q <= '0;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rsp_valid  = rsp_valid_q;
    assign rsp_Result = res_q;
    assign rsp_flags  = flags_q;
    assign alu_A      = a_q;
    assign alu_B      = b_q;
    assign alu_ALUop  = op_q;
    assign busy       = busy_q;

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single combinational ALU between NREQ requesters, e.g. the execute stage, the branch comparator and the address generator of the multi-cycle CPU.
- Each requester has a valid/ready request channel and a valid/ready response channel.
- Grants are round-robin. Operands are registered before they drive the ALU, and the ALU outputs are registered before they are returned.
- One operation is in flight at a time. The block sits between the requesters and the ALU instance.

Parameters:
- DATA_WIDTH, 32, operand and result width; must match the ALU.
- NREQ, 2, number of requesters; legal range 2..4.
- IDW, 2, width of the grant index; must satisfy 2**IDW >= NREQ.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req_valid  input  NREQ  request valid; bit i belongs to requester i.
- req_ready  output  NREQ  request accepted this cycle; one-hot or zero.
- req_A  input  NREQ*DATA_WIDTH  operand A; slice i is [i*DATA_WIDTH +: DATA_WIDTH].
- req_B  input  NREQ*DATA_WIDTH  operand B, sliced the same way as req_A.
- req_ALUop  input  NREQ*3  operation code; slice i is [i*3 +: 3].
- rsp_valid  output  NREQ  response valid for requester i.
- rsp_ready  input  NREQ  requester i accepts its response.
- rsp_Result  output  DATA_WIDTH  result, shared by all requesters; qualified by rsp_valid.
- rsp_flags  output  3  {Overflow, CarryOut, Zero}; shared, qualified by rsp_valid.
- alu_A  output  DATA_WIDTH  registered operand A to the ALU.
- alu_B  output  DATA_WIDTH  registered operand B to the ALU.
- alu_ALUop  output  3  registered opcode to the ALU.
- alu_Result  input  DATA_WIDTH  ALU result.
- alu_Overflow  input  1  ALU overflow flag.
- alu_CarryOut  input  1  ALU carry-out flag.
- alu_Zero  input  1  ALU zero flag.
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (asynchronous, active-high) forces:
  - FSM to IDLE.
  - req_ready, rsp_valid, busy to 0.
  - alu_A, alu_B, rsp_Result to 0; alu_ALUop to 3'b000; rsp_flags to 0.
  - grant index to 0; last-grant pointer to NREQ-1, so requester 0 has first priority.
- Reset asserted mid-operation aborts the operation. No response is ever issued for it, and requesters must re-issue.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If any req_valid is high, choose the winner: the first valid index scanning (last+1) mod NREQ upward with wrap-around.
  - Drive req_ready[winner]=1 combinationally in this cycle. The handshake completes this cycle because valid and ready are both high.
  - On the clock edge, latch the winner's A, B and ALUop into alu_A, alu_B, alu_ALUop, store the grant index, and go to EXEC.
  - If no req_valid is high, stay in IDLE and drive req_ready=0.
- EXEC (exactly one cycle): on the edge, capture alu_Result into rsp_Result and {alu_Overflow, alu_CarryOut, alu_Zero} into rsp_flags, then go to RESP.
- RESP:
  - rsp_valid[grant]=1; all other rsp_valid bits are 0.
  - Result, flags and rsp_valid are held stable until rsp_ready[grant] is sampled high.
  - On that edge: last-grant pointer becomes grant, rsp_valid clears, FSM returns to IDLE.
  - rsp_ready on any non-granted bit is ignored.
- req_ready is 0 in EXEC and RESP. A request held through those states waits and must keep its operands stable until it is accepted.
- Latency:
  - Acceptance in cycle T gives rsp_valid high in cycle T+2.
  - Minimum issue interval is 3 cycles, which occurs when the response is accepted in its first valid cycle.
- Fairness: with all requesters continuously valid, grants rotate 0,1,..,NREQ-1,0. No requester waits more than NREQ-1 operations.
- Registered alu_A, alu_B and alu_ALUop hold their last values in IDLE and RESP. Nothing in the block depends on them while idle.
- Width rules: no arithmetic is performed here. Data passes through unmodified, and the ALU's MUL result is the low 32 bits as delivered.

Decomposition:
- Package alu_pkg holds:
  - ALUop constants: ALU_ADD=3'b000, ALU_SUB=3'b001, ALU_SLT=3'b010, ALU_SLTU=3'b011, ALU_XOR=3'b100, ALU_MUL=3'b101, ALU_OR=3'b110, ALU_AND=3'b111.
  - DATA_WIDTH.
  - FSM state encoding: IDLE=2'd0, EXEC=2'd1, RESP=2'd2.
- Sub-module rr_picker: purely combinational round-robin picker.
  - Inputs: req vector, last pointer.
  - Outputs: one-hot grant, grant index, any.
  - Reusable by other shared-resource arbiters.

Test Plan:
- Single request: requester 0 sends A=5, B=3, op ALU_SUB, and rsp_ready is held high. Expect req_ready[0] in cycle T, rsp_valid[0] in cycle T+2, Result=2, flags=3'b000, then IDLE in T+3.
- Contention: both requesters valid from reset with ADD 1+1 and AND 0xF0&0x3C. Expect requester 0 served first (Result=2), then requester 1 (Result=0x30). With both requesters re-requesting, grants alternate 0,1,0,1.
- Backpressure: requester 1 sends 0x7FFFFFFF+1 (ADD) and holds rsp_ready=0 for 5 cycles. Expect Result=0x80000000 with Overflow=1 held stable throughout. req_ready stays 0 meanwhile even with requester 0 valid, and requester 0 is granted the cycle after acceptance.
- Flags: requester 0 sends SUB 3-3 → Result=0, Zero=1, CarryOut=0. SLTU 1<2 → Result=1. MUL 0x10000×0x10000 → Result=0, Zero=1.
- Async reset in EXEC: assert rst between edges. Expect busy, rsp_valid and req_ready at 0 immediately, no response ever for the aborted operation, and requester 0 granted first after release.
- NREQ=3 with requesters 1 and 2 valid after a grant to 1: expect the next grant to go to 2, then 1. Requester 0 is never granted while its valid bit is low.
